// File: rtl/fetch_queue_if.sv
// Handshake bundle for fetch_queue: PC side, instruction-memory side, decode side and flush.
// master = the queue itself, slave = the surrounding pipeline/memory.
interface fetch_queue_if #(
    parameter int bPC = 7,
    parameter int IW  = 32
);
    logic [bPC-1:0] pc_in;
    logic           pc_valid;
    logic           pc_ready;
    logic           imem_req;
    logic [bPC-1:0] imem_addr;
    logic           imem_ack;
    logic [IW-1:0]  imem_rdata;
    logic           flush;
    logic           id_valid;
    logic [IW-1:0]  id_instr;
    logic [bPC-1:0] id_pc;
    logic           id_ready;

    modport master (
        input  pc_in, pc_valid, imem_ack, imem_rdata, flush, id_ready,
        output pc_ready, imem_req, imem_addr, id_valid, id_instr, id_pc
    );

    modport slave (
        output pc_in, pc_valid, imem_ack, imem_rdata, flush, id_ready,
        input  pc_ready, imem_req, imem_addr, id_valid, id_instr, id_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one-outstanding imem requests, DEPTH-entry {pc,instr} buffer, flush.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards an ack straight to decode when the queue is empty.
module fetch_queue #(
    parameter int bPC   = 7,
    parameter int IW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    fetch_queue_if.master fq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic [bPC-1:0]  addr_q, addr_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [IW-1:0]   instr_mem_q [DEPTH];
    logic [bPC-1:0]  pc_mem_q [DEPTH];

    logic            pc_ready_s;
    logic            accept_s;
    logic            head_valid_s;
    logic            push_s;
    logic            pop_s;
    logic            id_valid_s;
    logic [IW-1:0]   id_instr_s;
    logic [bPC-1:0]  id_pc_s;
`ifdef FETCH_QUEUE_BYPASS_EN
    logic            bypass_s;
`endif

    // Acceptance, push/pop qualification and decode-side head selection.
    always_comb begin
        pc_ready_s   = !reset && !fq.flush && (state_q == ST_IDLE) && (count_q < DEPTH_C);
        accept_s     = fq.pc_valid && pc_ready_s;
        head_valid_s = (count_q != {CW{1'b0}});
        pop_s        = head_valid_s && fq.id_ready;
        id_valid_s   = head_valid_s;
        id_instr_s   = instr_mem_q[head_q];
        id_pc_s      = pc_mem_q[head_q];
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_s = !head_valid_s && (state_q == ST_REQ) && fq.imem_ack && !fq.flush;
        // A bypassed response taken by decode this cycle never enters storage.
        push_s   = (state_q == ST_REQ) && fq.imem_ack && !fq.flush && !(bypass_s && fq.id_ready);
        if (bypass_s) begin
            id_valid_s = 1'b1;
            id_instr_s = fq.imem_rdata;
            id_pc_s    = addr_q;
        end else begin
            id_valid_s = head_valid_s;
            id_instr_s = instr_mem_q[head_q];
            id_pc_s    = pc_mem_q[head_q];
        end
`else
        push_s   = (state_q == ST_REQ) && fq.imem_ack && !fq.flush;
`endif
    end

    // Pointer and occupancy next state; flush wins over any push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (fq.flush) begin
            head_d  = {AW{1'b0}};
            tail_d  = {AW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            if (pop_s) begin
                head_d = head_q + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                head_d = head_q;
            end
            if (push_s) begin
                tail_d = tail_q + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                tail_d = tail_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
        end
    end

    // Request FSM: requests are always carried to their ack, even across a flush.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    addr_d  = fq.pc_in;
                end else begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end
            ST_REQ: begin
                if (fq.imem_ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end else if (fq.flush) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (fq.imem_ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= {bPC{1'b0}};
            head_q  <= {AW{1'b0}};
            tail_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage, written at the tail on a qualified push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= {IW{1'b0}};
                pc_mem_q[i]    <= {bPC{1'b0}};
            end
        end else if (push_s) begin
            instr_mem_q[tail_q] <= fq.imem_rdata;
            pc_mem_q[tail_q]    <= addr_q;
        end
    end

    assign fq.pc_ready  = pc_ready_s;
    assign fq.imem_req  = req_q;
    assign fq.imem_addr = addr_q;
    assign fq.id_valid  = id_valid_s;
    assign fq.id_instr  = id_instr_s;
    assign fq.id_pc     = id_pc_s;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue sitting between the program counter register and the IF/ID pipeline register. It consumes fetch addresses from the PC, issues one-outstanding requests to instruction memory over a req/ack handshake, and buffers returned instructions with their PCs. Decode drains the buffer through a valid/ready interface. A flush from branch/jump resolution discards all buffered and in-flight instructions.

## Interface
- bPC, 7: PC/address width in bits (word address).
- IW, 32: instruction width.
- DEPTH, 4: queue entries; power of 2, ≥2.

- clock  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-high; clock clock.
- pc_in  in  bPC  next fetch address from PC register.
- pc_valid  in  1  pc_in is valid.
- pc_ready  out  1  address accepted this cycle; PC may advance.
- imem_req  out  1  memory request, registered.
- imem_addr  out  bPC  request address, registered.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  IW  instruction data, valid when imem_ack=1.
- flush  in  1  discard queued and in-flight instructions.
- id_valid  out  1  head entry valid.
- id_instr  out  IW  head instruction.
- id_pc  out  bPC  PC of head instruction.
- id_ready  in  1  decode consumes head this cycle.

## Operation
- States: IDLE (no request outstanding), REQ (imem_req=1, waiting ack), DRAIN (request outstanding after flush; response discarded).
- pc_ready = !reset && !flush && state==IDLE && count<DEPTH (combinational).
- IDLE: pc_valid && pc_ready → imem_addr<=pc_in, imem_req<=1, state<=REQ.
- REQ: imem_req and imem_addr held stable until imem_ack. On imem_ack: push {imem_addr, imem_rdata} at tail, imem_req<=0, state<=IDLE.
- Only one request outstanding; space reserved at acceptance (count<DEPTH), so a push never overflows.
- Pop: id_valid && id_ready → head advances. id_valid = count!=0; id_instr/id_pc driven from head entry.
- Push and pop same cycle: count unchanged, both pointers advance; legal at full and at count=1.
- Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- flush (dominant over push/pop): count, head, tail <= 0 next edge. If state==REQ and imem_ack=0 → DRAIN (imem_req stays 1; requests are never abandoned). If imem_ack=1 same cycle → data discarded, state<=IDLE, imem_req<=0.
- DRAIN: on imem_ack, discard data, imem_req<=0, state<=IDLE. flush in DRAIN has no further effect.

## Timing
- Reset (async): state=IDLE, imem_req=0, imem_addr=0, count/head/tail=0, id_valid=0; id_instr/id_pc=0 (storage cleared); pc_ready=0 while reset high.
- Reset mid-request: request dropped immediately; memory must tolerate req deassertion on reset.
- Zero-wait memory (ack in first REQ cycle): accept at cycle N, req high N+1, entry visible (id_valid=1) at N+2. Peak rate one fetch per 2 cycles.
- Every ack cycle in REQ/DRAIN returns to IDLE; pc_ready earliest the cycle after ack.
- Memory stall of k cycles lengthens REQ by k; id side unaffected.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count==0, state==REQ, imem_ack=1 and flush=0, id_valid=1 with id_instr=imem_rdata, id_pc=imem_addr combinationally; if id_ready=1 that cycle the entry is consumed and not pushed, otherwise pushed normally. Saves one cycle of fetch latency.
- Undefined: id outputs come only from storage; id_valid never depends on imem_ack.

## Test plan
- Reset then pc_valid=1, pc_in=0x05, memory acks next cycle with 0x8C220004, id_ready=1 → id_valid at accept+2, id_pc=0x05, id_instr=0x8C220004; pc_ready high again the cycle after ack.
- id_ready=0, fetch PCs 0..4 with zero-wait memory → 4 entries stored, pc_ready stays 0 at count=4; raise id_ready → pops in order PC 0,1,2,3, fetch of PC 4 proceeds.
- Memory stall 3 cycles → imem_req/imem_addr stable for 4 cycles, single push on ack.
- Flush while REQ, ack 2 cycles later → queue empty next edge, state DRAIN, acked data not delivered, pc_ready=0 until IDLE.
- Flush coincident with ack and pop at count=2 → count=0, no push, state IDLE next edge.
- With FETCH_QUEUE_BYPASS_EN, empty queue, id_ready=1, ack with 0x00000000 → id_valid=1 in ack cycle, count stays 0.
